// File: rtl/rdyack_pkg.sv
// Shared types and defaults for the rdy/ack stream sink.
package rdyack_pkg;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RETRACT = 2'd1,
        ERR_DATACHG = 2'd2
    } err_e;

    localparam int DEF_DW = 11;

endpackage

// File: rtl/rdyack_fifo.sv
// Small synchronous FIFO; head word is forced to zero while empty.
module rdyack_fifo
    import rdyack_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; count/pointers define validity and head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rdyack_sink.sv
// rdy/ack responder: patterned back-pressure, buffering FIFO, upstream protocol checker.
module rdyack_sink
    import rdyack_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = 4,
    parameter int PW    = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rdy,
    output logic          i_ack,
    input  logic [DW-1:0] i_data,
    output logic          o_rdy,
    input  logic          o_ack,
    output logic [DW-1:0] o_data,
    input  logic          stall_en,
    input  logic [PW-1:0] stall_pat,
    output logic          proto_err,
    output logic [1:0]    err_code,
    output logic [CW-1:0] xfer_cnt
);
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;

    logic [IW-1:0] idx;
    logic          full;
    logic          empty;
    logic          allow;
    logic          push;
    logic          pop;
    logic          pend;
    logic [DW-1:0] held_data;
    logic          viol;
    err_e          viol_code;
    err_e          err_q;

    // full is registered, so a same-cycle pop never opens a slot for the incoming word.
    assign allow = !stall_en || stall_pat[idx];
    assign i_ack = !rst && i_rdy && allow && !full;
    assign o_rdy = !rst && !empty;
    assign push  = i_rdy && i_ack;
    assign pop   = o_rdy && o_ack;

    assign err_code = err_q;

    rdyack_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (i_data),
        .full  (full),
        .empty (empty),
        .head  (o_data)
    );

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        viol      = 1'b0;
        viol_code = ERR_NONE;
        if (pend) begin
            if (!i_rdy) begin
                viol      = 1'b1;
                viol_code = ERR_RETRACT;
            end else if (i_data != held_data) begin
                viol      = 1'b1;
                viol_code = ERR_DATACHG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            pend      <= 1'b0;
            held_data <= '0;
            proto_err <= 1'b0;
            err_q     <= ERR_NONE;
            xfer_cnt  <= '0;
        end else begin
            idx       <= (idx == IW'(PW - 1)) ? '0 : idx + 1'b1;
            pend      <= i_rdy && !i_ack;
            held_data <= i_data;
            // Only the first violation is recorded until the next reset.
            if (viol && !proto_err) begin
                proto_err <= 1'b1;
                err_q     <= viol_code;
            end
            if (push) xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rdyack_sink.sv
// Directed bench for rdyack_sink: streaming, full back-pressure, stall pattern, checker, reset.
module tb_rdyack_sink;
    import rdyack_pkg::*;

    localparam int DW    = 11;
    localparam int DEPTH = 4;
    localparam int PW    = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_rdy;
    logic          i_ack;
    logic [DW-1:0] i_data;
    logic          o_rdy;
    logic          o_ack;
    logic [DW-1:0] o_data;
    logic          stall_en;
    logic [PW-1:0] stall_pat;
    logic          proto_err;
    logic [1:0]    err_code;
    logic [CW-1:0] xfer_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int slot    = 0;

    always #5 clk = ~clk;

    rdyack_sink #(.DW(DW), .DEPTH(DEPTH), .PW(PW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_rdy     (i_rdy),
        .i_ack     (i_ack),
        .i_data    (i_data),
        .o_rdy     (o_rdy),
        .o_ack     (o_ack),
        .o_data    (o_data),
        .stall_en  (stall_en),
        .stall_pat (stall_pat),
        .proto_err (proto_err),
        .err_code  (err_code),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; slot tracks the expected pattern index.
    task automatic tick();
        @(posedge clk);
        slot = rst ? 0 : (slot + 1) % PW;
        #1;
    endtask

    initial begin
        int  acc;
        bit  prev_acked;
        bit  exp_ack;

        rst = 1'b1; i_rdy = 1'b1; i_data = 11'h7ff; o_ack = 1'b0;
        stall_en = 1'b0; stall_pat = '0;
        #1;
        check("reset_iack", i_ack, 0);
        tick(); tick();
        rst = 1'b0; i_rdy = 1'b0;
        #1;
        check("reset_ordy", o_rdy, 0);
        check("reset_odata", o_data, 0);
        check("reset_err", proto_err, 0);
        check("reset_code", err_code, 0);
        check("reset_cnt", xfer_cnt, 0);

        // 1: continuous streaming, one-cycle latency
        o_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_rdy = 1'b1; i_data = DW'(k);
            #1;
            check($sformatf("s1_iack_%0d", k), i_ack, 1);
            if (k == 0) check("s1_ordy_first", o_rdy, 0);
            else begin
                check($sformatf("s1_ordy_%0d", k), o_rdy, 1);
                check($sformatf("s1_odata_%0d", k), o_data, k - 1);
            end
            tick();
        end
        i_rdy = 1'b0;
        #1;
        check("s1_last_ordy", o_rdy, 1);
        check("s1_last_odata", o_data, 9);
        check("s1_cnt", xfer_cnt, 10);
        tick();
        #1;
        check("s1_drained", o_rdy, 0);

        // 2: fill to DEPTH, no ack while full even with a pop
        o_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_rdy = 1'b1; i_data = DW'(11'h010 + k);
            #1;
            check($sformatf("s2_iack_%0d", k), i_ack, (k < 4) ? 1 : 0);
            tick();
        end
        o_ack = 1'b1;
        #1;
        check("s2_full_pop_iack", i_ack, 0);
        check("s2_head", o_data, 11'h010);
        tick();
        o_ack = 1'b0;
        #1;
        check("s2_after_pop_iack", i_ack, 1);
        tick();
        i_rdy = 1'b0; o_ack = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            check($sformatf("s2_drain_%0d", k), o_data, 11'h010 + k);
            tick();
        end
        #1;
        check("s2_empty", o_rdy, 0);
        check("s2_cnt", xfer_cnt, 15);
        check("s2_noerr", proto_err, 0);

        // 3: stall pattern allows slots 0 and 2 only
        stall_en = 1'b1; stall_pat = 8'b0000_0101;
        acc = 0; prev_acked = 1'b0;
        for (int c = 0; c < 24 && acc < 4; c++) begin
            i_rdy = 1'b1; i_data = DW'(11'h020 + acc);
            #1;
            exp_ack = (slot == 0) || (slot == 2);
            check($sformatf("s3_iack_c%0d", c), i_ack, exp_ack);
            if (prev_acked) check($sformatf("s3_odata_c%0d", c), o_data, 11'h020 + acc - 1);
            prev_acked = exp_ack;
            if (exp_ack) acc++;
            tick();
        end
        i_rdy = 1'b0; stall_en = 1'b0;
        #1;
        check("s3_last_odata", o_data, 11'h023);
        check("s3_cnt", xfer_cnt, 19);
        check("s3_noerr", proto_err, 0);
        tick();

        // 4: rdy retracted while stalled; later data change ignored
        stall_en = 1'b1; stall_pat = '0;
        i_rdy = 1'b1; i_data = 11'h123;
        #1;
        check("s4_stalled", i_ack, 0);
        tick();
        i_rdy = 1'b0;
        #1;
        check("s4_not_yet", proto_err, 0);
        tick();
        i_rdy = 1'b1; i_data = 11'h123;
        #1;
        check("s4_err", proto_err, 1);
        check("s4_code", err_code, ERR_RETRACT);
        tick();
        i_data = 11'h124;
        #1;
        tick();
        i_rdy = 1'b0;
        #1;
        check("s4_code_kept", err_code, ERR_RETRACT);
        tick();

        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        #1;
        check("s4_rst_err", proto_err, 0);
        check("s4_rst_code", err_code, ERR_NONE);

        // 5: data changed while stalled
        i_rdy = 1'b1; i_data = 11'h123;
        #1;
        tick();
        i_data = 11'h124;
        #1;
        check("s5_not_yet", proto_err, 0);
        tick();
        #1;
        check("s5_err", proto_err, 1);
        check("s5_code", err_code, ERR_DATACHG);

        // 6: reset mid-stream with 3 buffered words
        stall_en = 1'b0; o_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_rdy = 1'b1; i_data = DW'(11'h031 + k);
            #1;
            check($sformatf("s6_iack_%0d", k), i_ack, 1);
            tick();
        end
        rst = 1'b1; i_data = 11'h034;
        #1;
        check("s6_pre_cnt", xfer_cnt, 3);
        check("s6_rst_iack", i_ack, 0);
        check("s6_rst_ordy", o_rdy, 0);
        tick();
        rst = 1'b0; i_rdy = 1'b0;
        #1;
        check("s6_ordy", o_rdy, 0);
        check("s6_odata", o_data, 0);
        check("s6_cnt", xfer_cnt, 0);
        check("s6_err", proto_err, 0);
        check("s6_code", err_code, ERR_NONE);
        tick();
        #1;
        check("s6_unchecked", proto_err, 0);
        i_rdy = 1'b1; i_data = 11'h055; o_ack = 1'b1;
        #1;
        check("s6_resume_iack", i_ack, 1);
        tick();
        i_rdy = 1'b0;
        #1;
        check("s6_resume_ordy", o_rdy, 1);
        check("s6_resume_odata", o_data, 11'h055);
        check("s6_resume_cnt", xfer_cnt, 1);
        tick();
        #1;
        check("s6_resume_empty", o_rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
